// File: rtl/smi_req_frame_router_if.sv
// One SMI flit stream: Ready/Eofc/Data travel forward, Stop travels back.
interface smi_req_frame_router_if #(
  parameter int DataWidth = 128
);
  logic                 ready;
  logic [7:0]           eofc;
  logic [DataWidth-1:0] data;
  logic                 stop;

  modport master (output ready, eofc, data, input stop);
  modport slave  (input ready, eofc, data, output stop);
endinterface

// File: rtl/smi_req_frame_router.sv
// Steers whole SMI request frames to the write or read output by header type;
// frames of unknown type are swallowed and counted.
module smi_req_frame_router #(
  parameter int         DataIndexSize = 4,
  parameter logic [7:0] WriteReqId    = 8'h01,
  parameter logic [7:0] ReadReqId     = 8'h02,
  localparam int        DataWidth     = (1 << DataIndexSize) * 8
) (
  input  logic                    clk,
  input  logic                    srst,
  smi_req_frame_router_if.slave   smiIn,
  smi_req_frame_router_if.master  smiWr,
  smi_req_frame_router_if.master  smiRd,
  output logic [15:0]             dropCount
);

  typedef enum logic [1:0] {Idle, FwdWrite, FwdRead, Discard} state_t;

  state_t      stateReg;
  state_t      stateNext;
  logic        hdrIsWr;
  logic        hdrIsRd;
  logic        lastFlit;
  logic        inAccept;
  logic        frameDrop;
  logic [1:0]  outSel;
  logic [1:0]  outFull;
  logic [1:0]  outStop;
  logic [15:0] dropCountReg;

  assign hdrIsWr  = (smiIn.data[7:0] == WriteReqId);
  assign hdrIsRd  = (smiIn.data[7:0] == ReadReqId);
  assign lastFlit = (smiIn.eofc != 8'd0);
  assign outStop  = {smiRd.stop, smiWr.stop};

  // Stop depends only on routing and register state, never on smiIn.ready.
  assign smiIn.stop = |(outSel & outFull & outStop);
  assign inAccept   = smiIn.ready & ~smiIn.stop;

  always_ff @(posedge clk) begin
    if (srst) begin
      stateReg <= Idle;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      Idle: begin
        if (inAccept && !lastFlit) begin
          if (hdrIsWr) begin
            stateNext = FwdWrite;
          end else if (hdrIsRd) begin
            stateNext = FwdRead;
          end else begin
            stateNext = Discard;
          end
        end
      end
      default: begin
        if (inAccept && lastFlit) begin
          stateNext = Idle;
        end
      end
    endcase
  end

  always_comb begin
    outSel    = 2'b00;
    frameDrop = 1'b0;
    case (stateReg)
      Idle: begin
        outSel    = {hdrIsRd, hdrIsWr};
        frameDrop = inAccept && lastFlit && !hdrIsWr && !hdrIsRd;
      end
      FwdWrite: outSel = 2'b01;
      FwdRead:  outSel = 2'b10;
      default:  frameDrop = inAccept && lastFlit;
    endcase
  end

  // Index 0 is the write output, index 1 the read output.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_out
      logic                 readyReg;
      logic [7:0]           eofcReg;
      logic [DataWidth-1:0] dataReg;

      always_ff @(posedge clk) begin
        if (srst) begin
          readyReg <= 1'b0;
        end else if (inAccept && outSel[gi]) begin
          readyReg <= 1'b1;
        end else if (!outStop[gi]) begin
          readyReg <= 1'b0;
        end
        if (inAccept && outSel[gi]) begin
          eofcReg <= smiIn.eofc;
          dataReg <= smiIn.data;
        end
      end

      assign outFull[gi] = readyReg;
    end
  endgenerate

  assign smiWr.ready = g_out[0].readyReg;
  assign smiWr.eofc  = g_out[0].eofcReg;
  assign smiWr.data  = g_out[0].dataReg;
  assign smiRd.ready = g_out[1].readyReg;
  assign smiRd.eofc  = g_out[1].eofcReg;
  assign smiRd.data  = g_out[1].dataReg;

  always_ff @(posedge clk) begin
    if (srst) begin
      dropCountReg <= 16'd0;
    end else if (frameDrop && (dropCountReg != 16'hFFFF)) begin
      dropCountReg <= dropCountReg + 16'd1;
    end
  end

  assign dropCount = dropCountReg;

endmodule

// File: tb/tb_smi_req_frame_router.sv
// Directed stimulus with a queue scoreboard per output; a negedge monitor pops on transfer.
module tb_smi_req_frame_router;
  localparam int DW = 128;

  logic        clk = 1'b0;
  logic        srst;
  logic [15:0] dropCount;
  int          checkCount = 0;
  int          passCount  = 0;
  int          stallCount = 0;
  int          wrPopCount = 0;
  int          rdPopCount = 0;
  logic [DW+7:0] wrQ[$];
  logic [DW+7:0] rdQ[$];

  smi_req_frame_router_if #(.DataWidth(DW)) smiIn ();
  smi_req_frame_router_if #(.DataWidth(DW)) smiWr ();
  smi_req_frame_router_if #(.DataWidth(DW)) smiRd ();

  smi_req_frame_router #(.DataIndexSize(4)) dut (
    .clk       (clk),
    .srst      (srst),
    .smiIn     (smiIn),
    .smiWr     (smiWr),
    .smiRd     (smiRd),
    .dropCount (dropCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW+7:0] got, input logic [DW+7:0] want);
    checkCount++;
    if (got === want) begin
      passCount++;
    end else begin
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic failUnexpected(input string name, input logic [DW+7:0] got);
    checkCount++;
    $display("FAIL %s: got flit %0h want no flit", name, got);
  endtask

  // dest: 0 = dropped, 1 = write output, 2 = read output
  task automatic sendFlit(input int dest, input logic [7:0] eofc, input logic [DW-1:0] data);
    logic stopSeen;
    if (dest == 1) wrQ.push_back({eofc, data});
    else if (dest == 2) rdQ.push_back({eofc, data});
    smiIn.ready = 1'b1;
    smiIn.eofc  = eofc;
    smiIn.data  = data;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      stopSeen = smiIn.stop;
      @(posedge clk);
      if (!stopSeen) break;
      stallCount++;
      if (i > 200) begin
        $display("FAIL in_accept_timeout: got stalled %0d cycles want accept", i);
        $fatal(1, "input never accepted");
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (smiWr.ready === 1'b1) begin
      if (wrQ.size() == 0) failUnexpected("wr_unexpected", {smiWr.eofc, smiWr.data});
      else if (smiWr.stop == 1'b0) begin
        check("wr_flit", {smiWr.eofc, smiWr.data}, wrQ.pop_front());
        wrPopCount++;
      end
    end
    if (smiRd.ready === 1'b1) begin
      if (rdQ.size() == 0) failUnexpected("rd_unexpected", {smiRd.eofc, smiRd.data});
      else if (smiRd.stop == 1'b0) begin
        check("rd_flit", {smiRd.eofc, smiRd.data}, rdQ.pop_front());
        rdPopCount++;
      end
    end
  end

  initial begin
    srst = 1'b1;
    smiIn.ready = 1'b0;
    smiIn.eofc  = 8'd0;
    smiIn.data  = '0;
    smiWr.stop  = 1'b0;
    smiRd.stop  = 1'b0;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("rst_wr_ready", 136'(smiWr.ready), 136'(0));
    check("rst_rd_ready", 136'(smiRd.ready), 136'(0));
    check("rst_drop", 136'(dropCount), 136'(0));
    check("rst_in_stop", 136'(smiIn.stop), 136'(0));
    @(posedge clk); #1;

    // 3-flit write frame, full rate, 1-cycle latency
    sendFlit(1, 8'd0,  {120'hA0A0_1111_2222, 8'h01});
    sendFlit(1, 8'd0,  128'hB1B1_3333_4444_5555_6666_7777_8888_9999);
    sendFlit(1, 8'd16, 128'hC2C2_DEAD_BEEF_0000_FFFF_1234_5678_9ABC);
    smiIn.ready = 1'b0;
    @(negedge clk); #1;
    check("t1_wr_count", 136'(wrPopCount), 136'(3));
    check("t1_rd_count", 136'(rdPopCount), 136'(0));
    @(posedge clk); #1;

    // single-flit read immediately followed by 2-flit write
    stallCount = 0;
    sendFlit(2, 8'd4,  {120'h5151_AAAA, 8'h02});
    sendFlit(1, 8'd0,  {120'h6262_BBBB, 8'h01});
    sendFlit(1, 8'd16, 128'h7373_CCCC_DDDD);
    smiIn.ready = 1'b0;
    @(negedge clk); #1;
    check("t2_stalls", 136'(stallCount), 136'(0));
    check("t2_wr_count", 136'(wrPopCount), 136'(5));
    check("t2_rd_count", 136'(rdPopCount), 136'(1));
    @(posedge clk); #1;

    // write frame with 5 cycles of write backpressure mid-frame
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          sendFlit(1, (k == 5) ? 8'd16 : 8'd0,
                   (k == 0) ? {120'h9000_0000, 8'h01} : 128'(128'h9000_0000_0000_0100 + k));
        end
        smiIn.ready = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 smiWr.stop = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_in_stop", 136'(smiIn.stop), 136'(1));
        check("t3_wr_held", 136'(smiWr.ready), 136'(1));
        repeat (4) @(posedge clk);
        #1 smiWr.stop = 1'b0;
      end
    join
    @(negedge clk); #1;
    check("t3_wr_count", 136'(wrPopCount), 136'(11));
    check("t3_rd_count", 136'(rdPopCount), 136'(1));
    @(posedge clk); #1;

    // unknown 4-flit frame while both outputs are stopped
    smiWr.stop = 1'b1;
    smiRd.stop = 1'b1;
    stallCount = 0;
    sendFlit(0, 8'd0, {120'h7A7A_0001, 8'h7A});
    sendFlit(0, 8'd0, 128'h7A7A_0002);
    sendFlit(0, 8'd0, 128'h7A7A_0003);
    check("t4_drop_before_last", 136'(dropCount), 136'(0));
    sendFlit(0, 8'd8, 128'h7A7A_0004);
    check("t4_drop_after_last", 136'(dropCount), 136'(1));
    check("t4_stalls", 136'(stallCount), 136'(0));

    // 65536 single-flit unknown frames saturate the counter
    smiIn.eofc  = 8'd1;
    smiIn.data  = {120'h0, 8'h7A};
    smiIn.ready = 1'b1;
    repeat (65533) @(posedge clk);
    #1 check("t4_drop_fffe", 136'(dropCount), 136'(16'hFFFE));
    @(posedge clk);
    #1 check("t4_drop_ffff", 136'(dropCount), 136'(16'hFFFF));
    repeat (2) @(posedge clk);
    #1 check("t4_drop_no_wrap", 136'(dropCount), 136'(16'hFFFF));
    smiIn.ready = 1'b0;
    smiWr.stop  = 1'b0;
    smiRd.stop  = 1'b0;
    @(posedge clk); #1;

    // reset on the 2nd flit of a write frame, then a fresh read frame
    sendFlit(1, 8'd0, {120'hE0E0_0001, 8'h01});
    smiIn.data = 128'hE0E0_0002;
    smiIn.eofc = 8'd0;
    srst = 1'b1;
    @(posedge clk);
    #1 srst = 1'b0;
    smiIn.ready = 1'b0;
    check("t5_wr_ready", 136'(smiWr.ready), 136'(0));
    check("t5_drop", 136'(dropCount), 136'(0));
    sendFlit(2, 8'd0,   {120'hF1F1_0001, 8'h02});
    sendFlit(2, 8'hFF,  128'hF1F1_0002);
    smiIn.ready = 1'b0;
    @(negedge clk); #1;
    check("t5_rd_count", 136'(rdPopCount), 136'(3));
    check("t5_wr_count", 136'(wrPopCount), 136'(12));

    for (int i = 0; i < 20 && (wrQ.size() + rdQ.size()) != 0; i++) @(negedge clk);
    check("end_wr_queue_empty", 136'(wrQ.size()), 136'(0));
    check("end_rd_queue_empty", 136'(rdQ.size()), 136'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/smi_req_frame_router.md
Name: smi_req_frame_router

Overview:
- Sits directly upstream of the SMI-to-AXI write adaptor (and its read counterpart).
- Takes the single SMI request flit stream from the fabric and steers each frame, whole and unmodified, to the write-request or read-request output using the frame type byte in the first flit.
- Frames with an unrecognised type are consumed and dropped; a saturating counter records how many.
- The downstream adaptors can therefore rely on receiving only correctly typed frames.

Parameters:
DataIndexSize, 4, log2 of bytes per flit; DataWidth = (1 << DataIndexSize) * 8.
WriteReqId, 8'h01, frame type byte that selects the write output.
ReadReqId, 8'h02, frame type byte that selects the read output.

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
smiInReady  in  1  input flit valid
smiInEofc  in  8  0 = mid-frame flit; 1..DataWidth/8 = last flit, valid byte count
smiInData  in  DataWidth  input flit data; frame type in [7:0] of first flit
smiInStop  out  1  backpressure to upstream
smiWrReady  out  1  write output flit valid
smiWrEofc  out  8  write output end-of-frame control
smiWrData  out  DataWidth  write output data
smiWrStop  in  1  backpressure from write adaptor
smiRdReady  out  1  read output flit valid
smiRdEofc  out  8  read output end-of-frame control
smiRdData  out  DataWidth  read output data
smiRdStop  in  1  backpressure from read adaptor
dropCount  out  16  saturating count of discarded frames

Behaviour:
- Handshake:
  - A flit transfers on any port in a cycle where Ready=1 and Stop=0.
  - Ready, once asserted, holds with Eofc and Data stable until the transfer.
- Each output has a single output register stage, Wr and Rd independent.
  - The register loads when empty, or when full and Stop=0 in the same cycle, so back-to-back flits flow at full rate.
  - Input to output latency is 1 cycle.
- State machine, one state register:
  - Idle: the next input flit is a frame header.
    - smiInData[7:0]==WriteReqId -> route to Wr.
    - ==ReadReqId -> route to Rd.
    - Otherwise -> Discard.
    - If the header flit has Eofc!=0 (single-flit frame), the state stays Idle after acceptance. Otherwise it moves to FwdWrite, FwdRead or Discard.
  - FwdWrite / FwdRead: every flit goes to the selected output. On acceptance of a flit with Eofc!=0 -> Idle.
  - Discard: flits are accepted unconditionally, smiInStop=0. On acceptance of a flit with Eofc!=0 -> Idle, and dropCount increments once per discarded frame.
  - Single-flit unknown frames increment dropCount directly from Idle.
- smiInStop:
  - 1 when the selected output register is full and that output's Stop=1.
  - In Idle, it is evaluated against the output chosen by the current header; an unknown header is never stopped.
  - Combinational from the Stop inputs and the register-full flags. No path from smiInReady to smiInStop.
- The unselected output never changes while a frame is in progress on the other output.
- The frame is forwarded unmodified: header flit included, Eofc and Data bit-exact.
- dropCount: 16-bit, saturates at 16'hFFFF and does not wrap.
- Simultaneous events:
  - A header may be accepted in the same cycle the previous frame's last flit drains from the opposite output register.
  - A new frame to the same output pipelines behind the previous frame without a bubble.
- Reset, synchronous on srst=1:
  - state=Idle.
  - smiWrReady=0, smiRdReady=0, dropCount=0.
  - smiInStop is then determined by the combinational rule above; with both registers empty it is 0.
  - Data and Eofc registers are not reset and are don't-care while Ready=0.
  - Reset mid-frame abandons the partial frame in both the router and its output registers. The first flit after srst deasserts is treated as a header; upstream must also have been reset.
- Eofc values greater than DataWidth/8 are passed through unchecked.

Test Plan:
- Write frame, 3 flits, header data[7:0]=8'h01, Eofc 0,0,16, both Stops=0 -> smiWrReady high for 3 consecutive cycles starting 1 cycle after input, data identical, smiRdReady stays 0.
- Single-flit read frame (type 8'h02, Eofc=4) followed immediately by a 2-flit write frame -> Rd receives 1 flit, Wr receives 2 flits, no idle cycle on the input (smiInStop=0 throughout).
- Write frame with smiWrStop held 1 for 5 cycles mid-frame -> smiInStop=1 while the register is full, no flit lost or duplicated, order preserved, Rd untouched.
- Unknown type 8'h7A, 4 flits, with smiWrStop=smiRdStop=1 -> all flits accepted with smiInStop=0, no output Ready, dropCount 0->1 on the last flit; 65536 unknown single-flit frames -> dropCount saturates at 16'hFFFF.
- srst asserted on the 2nd flit of a 4-flit write frame -> next cycle smiWrReady=0 and dropCount=0; a fresh read frame after reset routes to Rd.
